// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register-file write request payload and write-port arbiter constants.
package cpu_types_pkg;

  localparam int RF_ADDR_W     = 5;
  localparam int RF_DATA_W     = 32;
  localparam int RF_WR_NUM_REQ = 2;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] rd_addr;
    logic [RF_DATA_W-1:0] wb_data;
  } rf_wr_req_t;

endpackage

// File: rtl/rf_wr_pick.sv
// Combinational grant logic for the register-file write arbiter; one-hot grant output.
// RF_WR_ARB_RR_EN selects round-robin on last_gnt, otherwise fixed priority with starvation escape.
module rf_wr_pick
  import cpu_types_pkg::*;
`ifndef RF_WR_ARB_RR_EN
#(
  parameter int MAX_WAIT = 4,
  parameter int WCW      = $clog2(MAX_WAIT + 1)
)
`endif
(
  input  logic [RF_WR_NUM_REQ-1:0] valid,
`ifdef RF_WR_ARB_RR_EN
  input  logic                     last_gnt,
`else
  input  logic [WCW-1:0]           wait_cnt,
`endif
  output logic [RF_WR_NUM_REQ-1:0] gnt
);

`ifdef RF_WR_ARB_RR_EN
  // On contention the port that did not win last time goes next.
  assign gnt[0] = valid[0] & (~valid[1] |  last_gnt);
  assign gnt[1] = valid[1] & (~valid[0] | ~last_gnt);
`else
  logic starved;
  assign starved = (wait_cnt == WCW'(MAX_WAIT));
  assign gnt[0]  = valid[0] & (~valid[1] | ~starved);
  assign gnt[1]  = valid[1] & (~valid[0] |  starved);
`endif

endmodule

// File: rtl/rf_wr_arbiter.sv
// Two-requester arbiter for the single register-file write port with a registered write stage.
// Define RF_WR_ARB_RR_EN for round-robin; default build is fixed priority with starvation escape.
module rf_wr_arbiter
  import cpu_types_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              rf_wen,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_data,
  output logic              rf_src
);

  logic [RF_WR_NUM_REQ-1:0] valid, gnt, fire;
  rf_wr_req_t               req [RF_WR_NUM_REQ];
  rf_wr_req_t               sel;

  assign valid  = {req1_valid, req0_valid};
  assign req[0] = '{rd_addr: req0_addr, wb_data: req0_data};
  assign req[1] = '{rd_addr: req1_addr, wb_data: req1_data};

  // Grants are only issued to valid ports, so a masked grant is the fire vector.
  assign fire       = rst ? '0 : gnt;
  assign req0_ready = fire[0];
  assign req1_ready = fire[1];
  assign sel        = fire[1] ? req[1] : req[0];

`ifdef RF_WR_ARB_RR_EN
  logic last_gnt;

  always_ff @(posedge clk) begin
    if (rst)        last_gnt <= 1'b1;
    else if (|fire) last_gnt <= fire[1];
  end

  rf_wr_pick u_pick (
    .valid    (valid),
    .last_gnt (last_gnt),
    .gnt      (gnt)
  );
`else
  localparam int WCW = $clog2(MAX_WAIT + 1);
  logic [WCW-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst)                            wait_cnt <= '0;
    else if (!req1_valid || fire[1])    wait_cnt <= '0;
    else if (wait_cnt != WCW'(MAX_WAIT)) wait_cnt <= wait_cnt + 1'b1;
  end

  rf_wr_pick #(.MAX_WAIT(MAX_WAIT), .WCW(WCW)) u_pick (
    .valid    (valid),
    .wait_cnt (wait_cnt),
    .gnt      (gnt)
  );
`endif

  // x0 writes complete the handshake but never pulse the port.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wen  <= 1'b0;
      rf_addr <= '0;
      rf_data <= '0;
      rf_src  <= 1'b0;
    end else if (|fire) begin
      rf_wen  <= |sel.rd_addr;
      rf_addr <= sel.rd_addr;
      rf_data <= sel.wb_data;
      rf_src  <= fire[1];
    end else begin
      rf_wen  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed self-checking bench for rf_wr_arbiter; covers both policies via RF_WR_ARB_RR_EN.
module tb_rf_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready;
  logic [4:0]  req0_addr;
  logic [31:0] req0_data;
  logic        req1_valid, req1_ready;
  logic [4:0]  req1_addr;
  logic [31:0] req1_data;
  logic        rf_wen, rf_src;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rf_wr_arbiter #(.DATA_W(32), .ADDR_W(5), .MAX_WAIT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .rf_wen     (rf_wen),
    .rf_addr    (rf_addr),
    .rf_data    (rf_data),
    .rf_src     (rf_src)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h1;
    req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'h2;
    tick();
    tick();
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_wen",    rf_wen,     0);
    chk("rst_addr",   rf_addr,    0);
    chk("rst_data",   rf_data,    0);
    chk("rst_src",    rf_src,     0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;
    tick();

    // Single port 0 write.
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
    #1;
    chk("p0_ready0", req0_ready, 1);
    chk("p0_ready1", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    chk("p0_wen",  rf_wen,  1);
    chk("p0_addr", rf_addr, 5);
    chk("p0_data", rf_data, 32'hDEADBEEF);
    chk("p0_src",  rf_src,  0);
    tick();
    chk("p0_wen_clr",   rf_wen,  0);
    chk("p0_addr_hold", rf_addr, 5);

    // Port 1 write to x0: handshake completes, no write pulse.
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h1234;
    #1;
    chk("x0_ready1", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    chk("x0_wen",  rf_wen,  0);
    chk("x0_src",  rf_src,  1);
    chk("x0_data", rf_data, 32'h1234);
    tick();

    // Continuous contention for 10 cycles.
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'hA0;
    req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'hB1;
    for (int k = 0; k < 10; k++) begin
      logic exp1;
`ifdef RF_WR_ARB_RR_EN
      exp1 = (k % 2) == 1;
`else
      exp1 = (k % 5) == 4;
`endif
      #1;
      chk($sformatf("cont_ready0[%0d]", k), req0_ready, !exp1);
      chk($sformatf("cont_ready1[%0d]", k), req1_ready, exp1);
      tick();
      chk($sformatf("cont_wen[%0d]", k),  rf_wen,  1);
      chk($sformatf("cont_src[%0d]", k),  rf_src,  exp1);
      chk($sformatf("cont_addr[%0d]", k), rf_addr, exp1 ? 7 : 3);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    chk("cont_wen_clr", rf_wen, 0);

    // Reset in the cycle after a fire drops the pending write and blocks readies.
    req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h99;
    tick();
    chk("rfire_wen", rf_wen, 1);
    rst = 1'b1;
    req1_valid = 1'b1; req1_addr = 5'd11;
    #1;
    chk("rmid_ready0", req0_ready, 0);
    chk("rmid_ready1", req1_ready, 0);
    tick();
    chk("rmid_wen",  rf_wen,  0);
    chk("rmid_addr", rf_addr, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;
    tick();

    // Port 1 alone: granted every cycle, back-to-back writes.
    req1_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      req1_addr = 5'(10 + k);
      req1_data = 32'h100 + 32'(k);
      #1;
      chk($sformatf("solo_ready1[%0d]", k), req1_ready, 1);
      tick();
      chk($sformatf("solo_wen[%0d]", k),  rf_wen,  1);
      chk($sformatf("solo_src[%0d]", k),  rf_src,  1);
      chk($sformatf("solo_addr[%0d]", k), rf_addr, 10 + k);
      chk($sformatf("solo_data[%0d]", k), rf_data, 32'h100 + k);
`ifndef RF_WR_ARB_RR_EN
      chk($sformatf("solo_wait[%0d]", k), dut.wait_cnt, 0);
`endif
    end
    req1_valid = 1'b0;
    tick();
    chk("end_wen", rf_wen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
